pll_drp_rmw: RTL and testbench
==============================

PLL_DRP_RMW -- requirements
Module: pll_drp_rmw

Interface
REQ-001 Parameter DRDY_TIMEOUT, default 64, meaning max dclk cycles from DEN to DRDY before abort.
REQ-002 Parameter LOCK_TIMEOUT, default 4096, meaning max dclk cycles from pll_rst release to pll_locked before abort.
REQ-003 Parameter RST_CYCLES, default 4, meaning dclk cycles pll_rst is held before the first DRP access.
REQ-004 Port dclk  input  1  DRP clock; all logic on rising edge; one clock only.
REQ-005 Port resetn  input  1  asynchronous, active-low reset.
REQ-006 Port cmd_valid  input  1  command request.
REQ-007 Port cmd_ready  output  1  block idle, command accepted when cmd_valid & cmd_ready.
REQ-008 Port cmd_write  input  1  1 = read-modify-write with PLL reset, 0 = read only.
REQ-009 Port cmd_addr  input  7  DRP register address.
REQ-010 Port cmd_mask  input  16  1 = keep readback bit, 0 = take cmd_data bit.
REQ-011 Port cmd_data  input  16  new field bits.
REQ-012 Port rsp_valid  output  1  one-cycle response strobe.
REQ-013 Port rsp_data  output  16  pre-modify readback value.
REQ-014 Port rsp_error  output  1  qualified by rsp_valid; 1 = DRDY or lock timeout.
REQ-015 Ports drp_daddr out 7, drp_den out 1, drp_dwe out 1, drp_di out 16, drp_do in 16, drp_drdy in 1  PLLE2_ADV DRP port.
REQ-016 Port pll_rst  output  1  drives PLLE2_ADV RST.
REQ-017 Port pll_locked  input  1  PLLE2_ADV LOCKED, treated as synchronous to dclk.

Function
REQ-018 States: IDLE, RST_HOLD, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT, RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; command fields SHALL be registered on acceptance and ignored thereafter.
REQ-020 Read-only path: IDLE -> RD -> RD_WAIT -> RESP -> IDLE; pll_rst SHALL stay 0.
REQ-021 Write path: IDLE -> RST_HOLD (pll_rst=1, RST_CYCLES cycles) -> RD -> RD_WAIT -> WR -> WR_WAIT -> LOCK_WAIT -> RESP -> IDLE.
REQ-022 RD and WR SHALL each last exactly one cycle with drp_den=1; drp_dwe=1 only in WR; drp_daddr = registered address in RD and WR, 0 otherwise.
REQ-023 drp_di SHALL equal (readback & mask) | (cmd_data & ~mask) in WR, 0 otherwise.
REQ-024 Readback SHALL be captured from drp_do on the cycle drp_drdy=1 in RD_WAIT.
REQ-025 drp_drdy SHALL be ignored outside RD_WAIT/WR_WAIT.
REQ-026 pll_rst SHALL deassert on the cycle WR_WAIT sees drp_drdy=1; LOCK_WAIT exits on pll_locked=1.
REQ-027 A single counter SHALL time each wait state, cleared on state entry; reaching DRDY_TIMEOUT in RD_WAIT/WR_WAIT or LOCK_TIMEOUT in LOCK_WAIT SHALL set an error flag and go to RESP.
REQ-028 On DRDY timeout pll_rst SHALL deassert immediately; no WR SHALL follow an RD_WAIT timeout.
REQ-029 RESP SHALL last one cycle: rsp_valid=1, rsp_data=readback (0 if never captured), rsp_error=flag.
REQ-030 Minimum read-only latency: acceptance to rsp_valid = 3 cycles with drp_drdy returned one cycle after DEN.
REQ-031 drdy and timeout limit in the same cycle: drdy SHALL win.

Reset
REQ-032 resetn=0 SHALL asynchronously force IDLE, cmd_ready=1 after release, all other outputs 0, counter and error flag cleared.
REQ-033 resetn asserted mid-operation SHALL abort any access and drop pll_rst at once; no partial response issued.

Verification
REQ-034 Read-only, addr 0x08, drp_do=0x1041, drdy 2 cycles after DEN -> one DEN pulse, dwe never 1, rsp_data=0x1041, rsp_error=0, pll_rst never 1.
REQ-035 Write, addr 0x14, mask 0xF000, data 0x0082, readback 0x1041 -> pll_rst high 4 cycles before DEN, drp_di=0x1082, pll_rst drops on write DRDY, rsp after pll_locked, rsp_error=0.
REQ-036 Read with drdy never asserted -> rsp_valid exactly 64 cycles after DEN, rsp_error=1, rsp_data=0.
REQ-037 Write with pll_locked held 0 -> rsp_error=1 after 4096 LOCK_WAIT cycles, pll_rst=0 throughout LOCK_WAIT.
REQ-038 resetn pulsed low during WR_WAIT -> pll_rst, drp_den, rsp_valid 0 immediately; next command executes normally.
REQ-039 Back-to-back cmd_valid held high with spurious drdy in IDLE -> second command accepted only after RESP, spurious drdy has no effect.

Source files
------------

// File: rtl/pll_drp_rmw.sv
// pll_drp_rmw: read-modify-write sequencer for a PLLE2_ADV DRP port.
//
// A read-only command issues one DRP read and returns the value. A write
// command first holds the PLL in reset. It then reads the register and
// merges in the new field bits under a mask. It writes the result back,
// releases the PLL reset and waits for lock before responding. Every wait is
// bounded, and an expired bound is reported through rsp_error.
//
// Ports
//   dclk, resetn            DRP clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_write               1 = read-modify-write with PLL reset, 0 = read
//   cmd_addr                DRP register address
//   cmd_mask, cmd_data      1 in mask keeps readback bit, 0 takes data bit
//   rsp_valid               one-cycle response strobe
//   rsp_data, rsp_error     pre-modify readback, timeout indication
//   drp_*                   PLLE2_ADV DRP port
//   pll_rst, pll_locked     PLLE2_ADV RST / LOCKED (LOCKED is dclk-synchronous)
module pll_drp_rmw #(
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned RST_CYCLES   = 4
) (
  input  logic        dclk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_mask,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  localparam int unsigned MAX_A   = (DRDY_TIMEOUT > RST_CYCLES) ? DRDY_TIMEOUT : RST_CYCLES;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LIM  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRDY_LIM = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, RST_HOLD, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT, RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             write_q;
  logic [6:0]       addr_q;
  logic [15:0]      mask_q;
  logic [15:0]      data_q;
  logic [15:0]      readback_q;

  // Outputs are registered: each transition loads the values that belong to
  // the state being entered, and the defaults below clear the strobes.
  // The DRP wait counter is cleared when entering RD/WR rather than the wait
  // state, so it measures DEN-to-DRDY and a timeout lands DRDY_TIMEOUT cycles
  // after DEN.
  always_ff @(posedge dclk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      err_q      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      readback_q <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
      drp_daddr  <= '0;
      drp_den    <= 1'b0;
      drp_dwe    <= 1'b0;
      drp_di     <= '0;
      pll_rst    <= 1'b0;
    end else begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
      drp_daddr <= '0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_di    <= '0;

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            write_q    <= cmd_write;
            addr_q     <= cmd_addr;
            mask_q     <= cmd_mask;
            data_q     <= cmd_data;
            readback_q <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
            if (cmd_write) begin
              state   <= RST_HOLD;
              pll_rst <= 1'b1;
            end else begin
              state     <= RD;
              drp_den   <= 1'b1;
              drp_daddr <= cmd_addr;
            end
          end
        end

        RST_HOLD: begin
          if (cnt == RST_LIM) begin
            state     <= RD;
            cnt       <= '0;
            drp_den   <= 1'b1;
            drp_daddr <= addr_q;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        RD: begin
          state <= RD_WAIT;
          cnt   <= cnt + CNT_ONE;
        end

        RD_WAIT: begin
          if (drp_drdy) begin
            readback_q <= drp_do;
            if (write_q) begin
              state     <= WR;
              cnt       <= '0;
              drp_den   <= 1'b1;
              drp_dwe   <= 1'b1;
              drp_daddr <= addr_q;
              drp_di    <= (drp_do & mask_q) | (data_q & ~mask_q);
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= drp_do;
              rsp_error <= err_q;
            end
          end else if (cnt == DRDY_LIM) begin
            state     <= RESP;
            err_q     <= 1'b1;
            pll_rst   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= readback_q;
            rsp_error <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        WR: begin
          state <= WR_WAIT;
          cnt   <= cnt + CNT_ONE;
        end

        WR_WAIT: begin
          if (drp_drdy) begin
            state   <= LOCK_WAIT;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else if (cnt == DRDY_LIM) begin
            state     <= RESP;
            err_q     <= 1'b1;
            pll_rst   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= readback_q;
            rsp_error <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        LOCK_WAIT: begin
          if (pll_locked) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= readback_q;
            rsp_error <= err_q;
          end else if (cnt == LOCK_LIM) begin
            state     <= RESP;
            err_q     <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data  <= readback_q;
            rsp_error <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        RESP: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          pll_rst   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_drp_rmw.sv
// tb_pll_drp_rmw: randomized and directed bench for pll_drp_rmw.
// A DRP/PLL responder is driven from a per-command timeline. The timeline
// is predicted from DRDY/lock latencies, and every output is checked each cycle.
`timescale 1ns/1ps
module tb_pll_drp_rmw;

  localparam int unsigned DT = 64;
  localparam int unsigned LT = 4096;
  localparam int unsigned RC = 4;

  logic        dclk = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_mask, cmd_data;
  logic        rsp_valid, rsp_error;
  logic [15:0] rsp_data;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe, drp_drdy;
  logic [15:0] drp_di, drp_do;
  logic        pll_rst, pll_locked;

  always #5 dclk = ~dclk;

  pll_drp_rmw #(.DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT), .RST_CYCLES(RC)) dut (
    .dclk(dclk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy),
    .pll_rst(pll_rst), .pll_locked(pll_locked)
  );

  // Command plus responder behaviour: dr/dw = cycles from DEN to DRDY for
  // the read/write access, dl = cycles from first pll_rst-low cycle to LOCKED.
  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [15:0] mask, data, rdval;
    int          dr, dw, dl;
  } txn_t;

  // Predicted timeline, in cycles after the acceptance edge (0 = never).
  typedef struct {
    int          den1, rdy1, den2, rdy2, lock_s, lock_k, resp, rst_last;
    logic [15:0] data, di;
    bit          err;
  } exp_t;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic txn_t mk(input bit wr, input logic [6:0] addr, input logic [15:0] mask,
                              input logic [15:0] data, input logic [15:0] rdval,
                              input int dr, input int dw, input int dl);
    txn_t t;
    t.wr = wr; t.addr = addr; t.mask = mask; t.data = data; t.rdval = rdval;
    t.dr = dr; t.dw = dw; t.dl = dl;
    return t;
  endfunction

  function automatic exp_t predict(input txn_t t);
    exp_t e;
    int   r0;
    e.den1 = 0; e.rdy1 = 0; e.den2 = 0; e.rdy2 = 0; e.lock_s = 0; e.lock_k = 0;
    e.resp = 0; e.rst_last = 0; e.data = '0; e.di = '0; e.err = 1'b0;
    r0 = t.wr ? int'(RC) : 0;
    e.den1 = r0 + 1;
    if (t.dr <= int'(DT) - 1) begin
      e.rdy1 = e.den1 + t.dr;
      e.data = t.rdval;
      if (!t.wr) begin
        e.resp = e.rdy1 + 1;
      end else begin
        e.den2 = e.rdy1 + 1;
        e.di   = (t.rdval & t.mask) | (t.data & ~t.mask);
        if (t.dw <= int'(DT) - 1) begin
          e.rdy2     = e.den2 + t.dw;
          e.rst_last = e.rdy2;
          e.lock_s   = e.rdy2 + 1;
          if (t.dl <= int'(LT) - 1) begin
            e.lock_k = e.lock_s + t.dl;
            e.resp   = e.lock_k + 1;
          end else begin
            e.resp = e.lock_s + int'(LT);
            e.err  = 1'b1;
          end
        end else begin
          e.resp     = e.den2 + int'(DT);
          e.err      = 1'b1;
          e.rst_last = e.resp - 1;
        end
      end
    end else begin
      e.resp     = e.den1 + int'(DT);
      e.err      = 1'b1;
      e.rst_last = t.wr ? e.resp - 1 : 0;
    end
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 32'({cmd_ready, drp_den, drp_dwe, pll_rst, rsp_valid}), 32'(5'b10000));
    check({tag, "_addr_di"}, 32'({drp_daddr, drp_di}), 32'(0));
  endtask

  // Entered just after a negedge with the DUT idle; returns just after the
  // negedge of the first idle cycle following the response.
  task automatic run_txn(input txn_t t, input bit spur, input bit keep_valid, input bit abort);
    exp_t       e;
    logic [4:0] ectl;
    bit         win;
    e = predict(t);
    check("ready_at_issue", 32'(cmd_ready), 32'(1));
    cmd_valid  = 1'b1;
    cmd_write  = t.wr;
    cmd_addr   = t.addr;
    cmd_mask   = t.mask;
    cmd_data   = t.data;
    drp_drdy   = 1'b0;
    pll_locked = 1'b0;
    for (int k = 1; k <= e.resp + 1; k++) begin
      @(negedge dclk);
      if (abort && k == e.den2 + 1) begin
        resetn = 1'b0;
        cmd_valid = 1'b0;
        drp_drdy = 1'b0;
        #1;
        check_reset_outputs("abort_now");
        @(negedge dclk);
        check_reset_outputs("abort_hold");
        resetn = 1'b1;
        return;
      end
      if (k <= e.resp) begin
        ectl = {1'b0, (k == e.den1) || (k == e.den2), k == e.den2, k <= e.rst_last, k == e.resp};
        check("ctl", 32'({cmd_ready, drp_den, drp_dwe, pll_rst, rsp_valid}), 32'(ectl));
        check("daddr", 32'(drp_daddr), ((k == e.den1) || (k == e.den2)) ? 32'(t.addr) : 32'(0));
        check("di", 32'(drp_di), (k == e.den2) ? 32'(e.di) : 32'(0));
        if (k == e.resp) begin
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_error", 32'(rsp_error), 32'(e.err));
        end
      end else begin
        check("ready_after_resp", 32'(cmd_ready), 32'(1));
        drp_drdy = 1'b0;
        return;
      end
      if (keep_valid) begin
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom);
        cmd_addr  = 7'($urandom);
        cmd_mask  = 16'($urandom);
        cmd_data  = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      win = (t.wr && k <= int'(RC)) || (e.lock_s != 0 && k >= e.lock_s && k <= e.resp);
      drp_drdy   = (k == e.rdy1) || (k == e.rdy2) || (spur && win && 1'($urandom));
      drp_do     = (k == e.rdy1) ? t.rdval : 16'($urandom);
      pll_locked = (e.lock_k != 0) && (k >= e.lock_k);
    end
  endtask

  task automatic idle(input int n, input bit spur);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      drp_drdy  = spur ? 1'($urandom) : 1'b0;
      drp_do    = 16'($urandom);
      @(negedge dclk);
      check("idle_ready", 32'({cmd_ready, drp_den, pll_rst, rsp_valid}), 32'(4'b1000));
    end
    drp_drdy = 1'b0;
  endtask

  initial begin
    txn_t t;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_mask = '0; cmd_data = '0; drp_do = '0; drp_drdy = 1'b0; pll_locked = 1'b0;
    repeat (3) @(negedge dclk);
    check_reset_outputs("reset");
    check("reset_rsp", 32'({rsp_data, rsp_error}), 32'(0));
    resetn = 1'b1;
    idle(2, 1'b0);

    // Directed cases
    run_txn(mk(1'b0, 7'h08, 16'h0000, 16'h0000, 16'h1041, 2, 0, 0), 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    run_txn(mk(1'b1, 7'h14, 16'hF000, 16'h0082, 16'h1041, 3, 2, 5), 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    run_txn(mk(1'b0, 7'h10, 16'h0000, 16'h0000, 16'hBEEF, 1000, 0, 0), 1'b0, 1'b0, 1'b0);
    run_txn(mk(1'b0, 7'h11, 16'h0000, 16'h0000, 16'h5A5A, 63, 0, 0), 1'b0, 1'b0, 1'b0);
    run_txn(mk(1'b0, 7'h12, 16'h0000, 16'h0000, 16'hA5A5, 64, 0, 0), 1'b0, 1'b0, 1'b0);
    run_txn(mk(1'b0, 7'h13, 16'h0000, 16'h0000, 16'h1234, 1, 0, 0), 1'b0, 1'b0, 1'b0);
    run_txn(mk(1'b1, 7'h15, 16'h00FF, 16'hCAFE, 16'h1357, 2, 2, 5000), 1'b1, 1'b0, 1'b0);
    run_txn(mk(1'b1, 7'h16, 16'h0F0F, 16'h9999, 16'h2468, 1, 1, 4095), 1'b0, 1'b0, 1'b0);
    run_txn(mk(1'b1, 7'h17, 16'hFF00, 16'h00AA, 16'h7777, 2, 1000, 0), 1'b0, 1'b0, 1'b0);
    run_txn(mk(1'b1, 7'h18, 16'hFF00, 16'h00AA, 16'h7777, 1000, 1, 0), 1'b0, 1'b0, 1'b0);
    run_txn(mk(1'b1, 7'h19, 16'h0000, 16'hFFFF, 16'h0001, 2, 1000, 0), 1'b0, 1'b0, 1'b1);
    run_txn(mk(1'b1, 7'h1A, 16'h8001, 16'h4242, 16'hF00F, 2, 3, 2), 1'b0, 1'b0, 1'b0);
    idle(4, 1'b1);
    run_txn(mk(1'b0, 7'h1B, 16'h0000, 16'h0000, 16'h0F0F, 3, 0, 0), 1'b1, 1'b1, 1'b0);
    run_txn(mk(1'b1, 7'h1C, 16'h3C3C, 16'hC3C3, 16'h6666, 2, 2, 1), 1'b1, 1'b1, 1'b0);
    run_txn(mk(1'b0, 7'h1D, 16'h0000, 16'h0000, 16'h8421, 1, 0, 0), 1'b1, 1'b0, 1'b0);

    // Randomized commands and responder latencies
    for (int n = 0; n < 40; n++) begin
      bit kv;
      t = mk(1'($urandom), 7'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), int'($urandom_range(0, 10)));
      kv = 1'($urandom);
      run_txn(t, 1'($urandom), kv, 1'b0);
      if (!kv) idle(int'($urandom_range(0, 3)), 1'b1);
    end

    cmd_valid = 1'b0;
    idle(2, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
